// File: rtl/tri_buf_if.sv
// Control and status bundle for tri_buf: drive request, drive data and the
// registered capture/contention results. The shared bus itself is a plain inout.
interface tri_buf_if #(
    parameter int WIDTH = 8
);
    logic             rw;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             contention;

    modport master (
        output rw,
        output data,
        input  rd_data,
        input  rd_valid,
        input  contention
    );

    modport slave (
        input  rw,
        input  data,
        output rd_data,
        output rd_valid,
        output contention
    );
endinterface

// File: rtl/tri_buf.sv
// Bidirectional tri-state bus buffer with a clocked capture path and an
// optional sticky contention detector (enabled by TRI_BUF_CONTENTION_EN).
module tri_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [WIDTH-1:0] bus,
    tri_buf_if.slave         s_if
);
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             w_contention;

    // Drive path is purely combinational and deliberately ignores rst_n.
    assign bus = s_if.rw ? s_if.data : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (!s_if.rw) begin
            r_rd_data  <= bus;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

`ifdef TRI_BUF_CONTENTION_EN
    logic r_contention;

    // 4-state compare so a fighting driver that resolves to X also trips the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contention <= 1'b0;
        end else if (s_if.rw && (bus !== s_if.data)) begin
            r_contention <= 1'b1;
        end
    end

    assign w_contention = r_contention;
`else
    assign w_contention = 1'b0;
`endif

    assign s_if.rd_data    = r_rd_data;
    assign s_if.rd_valid   = r_rd_valid;
    assign s_if.contention = w_contention;
endmodule

// File: tb/tb_tri_buf.sv
// Directed self-checking bench for tri_buf: drive/release, capture latency,
// contention flag and asynchronous reset behaviour.
module tb_tri_buf;
    localparam int WIDTH = 8;
`ifdef TRI_BUF_CONTENTION_EN
    localparam logic EXP_CONT = 1'b1;
`else
    localparam logic EXP_CONT = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             ext_en;
    logic [WIDTH-1:0] ext_val;
    wire  [WIDTH-1:0] bus;
    int               n_cmp;
    int               n_err;

    tri_buf_if #(.WIDTH(WIDTH)) u_if ();

    tri_buf #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .s_if  (u_if.slave)
    );

    // Second agent on the shared bus.
    assign bus = ext_en ? ext_val : {WIDTH{1'bz}};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [WIDTH-1:0] data,
                         input logic en, input logic [WIDTH-1:0] ev);
        u_if.rw   = rw;
        u_if.data = data;
        ext_en    = en;
        ext_val   = ev;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        #3;
        check("reset_rd_data", u_if.rd_data, 8'h00);
        check("reset_rd_valid", {7'd0, u_if.rd_valid}, 8'h00);
        check("reset_contention", {7'd0, u_if.contention}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Combinational drive path
        drive(1'b1, 8'h05, 1'b0, 8'h00);
        #1 check("drive_5", bus, 8'h05);
        drive(1'b1, 8'h3C, 1'b0, 8'h00);
        #1 check("drive_follow_data", bus, 8'h3C);
        drive(1'b0, 8'h06, 1'b1, 8'h81);
        #1 check("released_ext_wins", bus, 8'h81);
        drive(1'b1, 8'h06, 1'b0, 8'h00);
        #1 check("redrive_6", bus, 8'h06);

        // Capture with one-cycle rd_valid
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1, 8'hA5);
        after_edge();
        check("cap_A5_data", u_if.rd_data, 8'hA5);
        check("cap_A5_valid", {7'd0, u_if.rd_valid}, 8'h01);
        @(negedge clk);
        drive(1'b1, 8'h12, 1'b0, 8'h00);
        after_edge();
        check("cap_valid_drop", {7'd0, u_if.rd_valid}, 8'h00);
        check("cap_hold_A5", u_if.rd_data, 8'hA5);

        // Back-to-back captures
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b1, 8'h5A);
        after_edge();
        check("cap_5A_data", u_if.rd_data, 8'h5A);
        @(negedge clk);
        drive(1'b0, 8'h11, 1'b1, 8'hC3);
        #1 check("data_ignored_released", bus, 8'hC3);
        after_edge();
        check("cap_C3_data", u_if.rd_data, 8'hC3);
        check("cap_C3_valid", {7'd0, u_if.rd_valid}, 8'h01);

        // Contention
        @(negedge clk);
        drive(1'b1, 8'h0F, 1'b1, 8'hF0);
        #1 check("cont_before_edge", {7'd0, u_if.contention}, 8'h00);
        after_edge();
        check("cont_set", {7'd0, u_if.contention}, {7'd0, EXP_CONT});
        check("cont_no_capture", {7'd0, u_if.rd_valid}, 8'h00);
        @(negedge clk);
        ext_en = 1'b0;
        after_edge();
        check("cont_sticky", {7'd0, u_if.contention}, {7'd0, EXP_CONT});
        check("cont_bus_clean", bus, 8'h0F);

        // Asynchronous reset mid-operation; bus keeps following rw/data
        @(negedge clk);
        drive(1'b1, 8'h03, 1'b0, 8'h00);
        after_edge();
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd_data", u_if.rd_data, 8'h00);
        check("arst_rd_valid", {7'd0, u_if.rd_valid}, 8'h00);
        check("arst_contention", {7'd0, u_if.contention}, 8'h00);
        check("arst_bus", bus, 8'h03);
        after_edge();
        check("arst_bus_held", bus, 8'h03);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h03, 1'b1, 8'h42);
        after_edge();
        check("post_reset_cap", u_if.rd_data, 8'h42);
        check("post_reset_cont", {7'd0, u_if.contention}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
